// File: rtl/cibus_rx_buffer_pkg.sv
// Shared types and constants for the CI bus receive buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cibus_rx_buffer_pkg;

  // Default CI data width; instances may override it per build.
  localparam int CI_DATA_W = 128;

  // Width of the saturating truncation counter.
  localparam int ERR_CNT_W = 8;

  // Input framing FSM states.
  typedef enum logic [1:0] {
    IDLE,
    IN_PKT,
    DROP
  } ci_rx_state_e;

  // Per-beat framing tag. A FIFO entry is {tag, data}; the data part is kept
  // outside the struct so the entry can follow a per-instance DATA_W.
  typedef struct packed {
    logic last;  // last beat of packet (real ci_end or truncation point)
    logic err;   // packet was truncated at MAX_BEATS
  } ci_entry_tag_t;

endpackage

// File: rtl/cibus_rx_buffer_if.sv
// CI bus beat sink plus valid/ready beat source, bundled as one interface.
// Latency: n/a (wiring only).
// Backpressure: ci_busy towards the CI bus, out_ready from downstream.
// Ports: slave = receiver side (drives ci_busy and out_*), master = the peer
// that drives CI beats and out_ready.
interface cibus_rx_buffer_if #(
  parameter int DATA_W = 128
);
  logic              ci_valid;
  logic              ci_busy;
  logic [DATA_W-1:0] ci_data;
  logic              ci_end;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_end;
  logic              out_err;

  modport slave (
    input  ci_valid, ci_data, ci_end, out_ready,
    output ci_busy, out_valid, out_data, out_end, out_err
  );

  modport master (
    output ci_valid, ci_data, ci_end, out_ready,
    input  ci_busy, out_valid, out_data, out_end, out_err
  );
endinterface

// File: rtl/cibus_rx_buffer_fifo.sv
// Flop-array FIFO with first-word-fall-through read (rdat is the head entry).
// Latency: a push is visible at rdat/count one cycle later.
// Backpressure: none internally; caller must not push when full without a pop.
// Ports: clk/rst_n, push+wdat, pop, rdat (head), count, full, empty.
module cibus_rx_buffer_fifo #(
  parameter int W     = 130,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               wdat,
  input  logic                       pop,
  output logic [W-1:0]               rdat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointers wrap naturally at PW bits.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = wdat;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdat  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
endmodule

// File: rtl/cibus_rx_buffer.sv
// CI bus receiver: frames beats into packets, truncates overlong ones, buffers them.
// Latency: 1 cycle accept->out_valid (cut-through) or 1 cycle after ci_end (store-and-forward).
// Backpressure: registered ci_busy when the buffer will be full; out_valid/out_ready downstream.
// Ports: s_clk, rst_n, bus (CI sink + beat source), pkt_avail (complete packets held),
// err_cnt (saturating truncation count).
module cibus_rx_buffer
  import cibus_rx_buffer_pkg::*;
#(
  parameter int DATA_W    = CI_DATA_W,
  parameter int DEPTH     = 16,
  parameter int MODE_SF   = 1,
  parameter int MAX_BEATS = 16
) (
  input  logic                       s_clk,
  input  logic                       rst_n,
  cibus_rx_buffer_if.slave           bus,
  output logic [$clog2(DEPTH+1)-1:0] pkt_avail,
  output logic [ERR_CNT_W-1:0]       err_cnt
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int EW = DATA_W + 2;

  ci_rx_state_e         state_q, state_d;
  logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [CW-1:0]        pkt_q, pkt_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  logic          accept, push, do_push, pop, err_inc;
  ci_entry_tag_t tag, head_tag;
  logic [EW-1:0] fifo_rdat;
  logic [CW-1:0] fifo_count, cnt_next;
  logic          fifo_full, fifo_empty;

  assign accept = bus.ci_valid & ~busy_q;
  assign pop    = valid_q & bus.out_ready & ~fifo_empty;
  // busy already prevents a push into a full buffer; the gate is a backstop.
  assign do_push = push & (~fifo_full | pop);

  // Input framing: decides what (if anything) an accepted beat pushes.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    push       = 1'b0;
    tag        = '0;
    err_inc    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          push = 1'b1;
          if (bus.ci_end) begin
            tag.last = 1'b1;
          end else if (MAX_BEATS == 1) begin
            // A lone non-final beat already hits the limit.
            tag.last = 1'b1;
            tag.err  = 1'b1;
            err_inc  = 1'b1;
            state_d  = DROP;
          end else begin
            state_d    = IN_PKT;
            beat_cnt_d = BW'(1);
          end
        end
      end
      IN_PKT: begin
        if (accept) begin
          push       = 1'b1;
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (bus.ci_end) begin
            tag.last   = 1'b1;
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else if (beat_cnt_q == BW'(MAX_BEATS - 1)) begin
            // Close the stored packet here and discard the rest of it.
            tag.last   = 1'b1;
            tag.err    = 1'b1;
            err_inc    = 1'b1;
            state_d    = DROP;
            beat_cnt_d = '0;
          end
        end
      end
      DROP: begin
        if (accept && bus.ci_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  cibus_rx_buffer_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (s_clk),
    .rst_n (rst_n),
    .push  (do_push),
    .wdat  ({tag, bus.ci_data}),
    .pop   (pop),
    .rdat  (fifo_rdat),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_tag = fifo_rdat[EW-1 -: 2];

  always_comb begin
    cnt_next = fifo_count + CW'(do_push) - CW'(pop);
    pkt_d    = pkt_q + CW'(do_push & tag.last) - CW'(pop & head_tag.last);
    // Store-and-forward: the end entry of the head packet stays counted
    // until popped, so valid holds through the whole released packet.
    valid_d  = (MODE_SF != 0) ? (pkt_d != '0) : (cnt_next != '0);
    // Dropped beats never occupy the buffer, so DROP never stalls the bus.
    busy_d   = (cnt_next == CW'(DEPTH)) && (state_d != DROP);
    err_d    = (err_inc && (err_q != '1)) ? err_q + ERR_CNT_W'(1) : err_q;
  end

  always_ff @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      pkt_q      <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      pkt_q      <= pkt_d;
      err_q      <= err_d;
    end
  end

  assign bus.ci_busy   = busy_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = fifo_rdat[DATA_W-1:0];
  assign bus.out_end   = head_tag.last;
  assign bus.out_err   = head_tag.err;
  assign pkt_avail     = pkt_q;
  assign err_cnt       = err_q;
endmodule

// File: tb/tb_cibus_rx_buffer.sv
// Bench for cibus_rx_buffer: one store-and-forward and one cut-through instance.
// Latency: n/a.
// Backpressure: out_ready driven per test.
module tb_cibus_rx_buffer;
  localparam int DW = 32;

  logic s_clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 s_clk = ~s_clk;

  cibus_rx_buffer_if #(.DATA_W(DW)) sf_if ();
  cibus_rx_buffer_if #(.DATA_W(DW)) ct_if ();
  logic [4:0] sf_pkt, ct_pkt;
  logic [7:0] sf_err, ct_err;

  cibus_rx_buffer #(.DATA_W(DW), .DEPTH(16), .MODE_SF(1), .MAX_BEATS(4)) u_sf (
    .s_clk(s_clk), .rst_n(rst_n), .bus(sf_if), .pkt_avail(sf_pkt), .err_cnt(sf_err));
  cibus_rx_buffer #(.DATA_W(DW), .DEPTH(16), .MODE_SF(0), .MAX_BEATS(4)) u_ct (
    .s_clk(s_clk), .rst_n(rst_n), .bus(ct_if), .pkt_avail(ct_pkt), .err_cnt(ct_err));

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          err;
  } exp_t;

  typedef struct {
    int            nbeats;  // beats driven
    logic [DW-1:0] base;    // data of first beat, +1 per beat
    int            kept;    // beats expected at the output
    logic          trunc;   // last kept beat flagged err
  } pkt_vec_t;

  exp_t     sf_q[$];
  exp_t     ct_q[$];
  pkt_vec_t tbl[6];
  int       n_cmp = 0;
  int       n_bad = 0;
  logic     sf_acc, ct_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // One clock: sample handshakes at the falling edge, return 1ns after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge s_clk);
    sf_acc = sf_if.ci_valid && !sf_if.ci_busy;
    ct_acc = ct_if.ci_valid && !ct_if.ci_busy;
    if (sf_if.out_valid && sf_if.out_ready) begin
      if (sf_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sf_unexpected_beat: got data %0h, required no beat", sf_if.out_data);
      end else begin
        e = sf_q.pop_front();
        chk("sf_beat", 64'({sf_if.out_data, sf_if.out_end, sf_if.out_err}),
            64'({e.data, e.last, e.err}));
      end
    end
    if (ct_if.out_valid && ct_if.out_ready) begin
      if (ct_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL ct_unexpected_beat: got data %0h, required no beat", ct_if.out_data);
      end else begin
        e = ct_q.pop_front();
        chk("ct_beat", 64'({ct_if.out_data, ct_if.out_end, ct_if.out_err}),
            64'({e.data, e.last, e.err}));
      end
    end
    @(posedge s_clk);
    #1;
  endtask

  task automatic expect_beat(input bit sf, input logic [DW-1:0] d, input logic l, input logic r);
    exp_t e;
    e.data = d; e.last = l; e.err = r;
    if (sf) sf_q.push_back(e);
    else    ct_q.push_back(e);
  endtask

  // Drive one beat and hold it until accepted; returns right after the accepting edge.
  task automatic send(input bit sf, input logic [DW-1:0] d, input logic e);
    logic got;
    if (sf) begin sf_if.ci_valid = 1'b1; sf_if.ci_data = d; sf_if.ci_end = e; end
    else    begin ct_if.ci_valid = 1'b1; ct_if.ci_data = d; ct_if.ci_end = e; end
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      got = sf ? sf_acc : ct_acc;
    end
    chk("send_accept", 64'(got), 64'(1));
    if (sf) sf_if.ci_valid = 1'b0;
    else    ct_if.ci_valid = 1'b0;
  endtask

  task automatic drain(input bit sf);
    for (int i = 0; i < 60 && (sf ? sf_q.size() : ct_q.size()) != 0; i++) tick();
    tick();
    chk(sf ? "sf_drained" : "ct_drained", 64'(sf ? sf_q.size() : ct_q.size()), 64'(0));
  endtask

  initial begin
    int acc;
    logic [DW-1:0] d;

    tbl[0] = '{nbeats: 1, base: 32'h100, kept: 1, trunc: 1'b0};
    tbl[1] = '{nbeats: 2, base: 32'h200, kept: 2, trunc: 1'b0};
    tbl[2] = '{nbeats: 4, base: 32'h400, kept: 4, trunc: 1'b0};
    tbl[3] = '{nbeats: 5, base: 32'h500, kept: 4, trunc: 1'b1};
    tbl[4] = '{nbeats: 6, base: 32'h600, kept: 4, trunc: 1'b1};
    tbl[5] = '{nbeats: 3, base: 32'h300, kept: 3, trunc: 1'b0};

    sf_if.ci_valid = 1'b0; sf_if.ci_data = '0; sf_if.ci_end = 1'b0; sf_if.out_ready = 1'b1;
    ct_if.ci_valid = 1'b0; ct_if.ci_data = '0; ct_if.ci_end = 1'b0; ct_if.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_sf_busy",  64'(sf_if.ci_busy),   64'(0));
    chk("rst_sf_valid", 64'(sf_if.out_valid), 64'(0));
    chk("rst_sf_data",  64'(sf_if.out_data),  64'(0));
    chk("rst_sf_end",   64'(sf_if.out_end),   64'(0));
    chk("rst_sf_err",   64'(sf_if.out_err),   64'(0));
    chk("rst_sf_pkt",   64'(sf_pkt),          64'(0));
    chk("rst_sf_errc",  64'(sf_err),          64'(0));
    chk("rst_ct_valid", 64'(ct_if.out_valid), 64'(0));
    chk("rst_ct_pkt",   64'(ct_pkt),          64'(0));
    @(negedge s_clk); rst_n = 1'b1;
    @(posedge s_clk); #1;

    // Store-and-forward: nothing released until the end beat lands
    expect_beat(1'b1, 32'hA1, 1'b0, 1'b0);
    expect_beat(1'b1, 32'hA2, 1'b0, 1'b0);
    expect_beat(1'b1, 32'hA3, 1'b1, 1'b0);
    send(1'b1, 32'hA1, 1'b0);
    chk("sf_hold_a1", 64'(sf_if.out_valid), 64'(0));
    send(1'b1, 32'hA2, 1'b0);
    chk("sf_hold_a2", 64'(sf_if.out_valid), 64'(0));
    send(1'b1, 32'hA3, 1'b1);
    chk("sf_release_valid", 64'(sf_if.out_valid), 64'(1));
    chk("sf_release_pkt",   64'(sf_pkt),          64'(1));
    tick();
    chk("sf_body_valid1", 64'(sf_if.out_valid), 64'(1));
    tick();
    chk("sf_body_valid2", 64'(sf_if.out_valid), 64'(1));
    tick();
    chk("sf_done_valid", 64'(sf_if.out_valid), 64'(0));
    chk("sf_done_pkt",   64'(sf_pkt),          64'(0));
    chk("sf_done_q",     64'(sf_q.size()),     64'(0));

    // Cut-through: single-beat packet visible the cycle after acceptance
    expect_beat(1'b0, 32'hDEAD, 1'b1, 1'b0);
    send(1'b0, 32'hDEAD, 1'b1);
    chk("ct_valid", 64'(ct_if.out_valid), 64'(1));
    chk("ct_data",  64'(ct_if.out_data),  64'(32'hDEAD));
    chk("ct_end",   64'(ct_if.out_end),   64'(1));
    chk("ct_err",   64'(ct_if.out_err),   64'(0));
    tick();
    chk("ct_valid_after", 64'(ct_if.out_valid), 64'(0));

    // Packet table on the cut-through instance (MAX_BEATS = 4)
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < tbl[p].nbeats; k++) begin
        if (k < tbl[p].kept)
          expect_beat(1'b0, tbl[p].base + 32'(k), (k == tbl[p].kept - 1),
                      tbl[p].trunc && (k == tbl[p].kept - 1));
        send(1'b0, tbl[p].base + 32'(k), (k == tbl[p].nbeats - 1));
      end
    end
    drain(1'b0);
    chk("ct_err_cnt", 64'(ct_err), 64'(2));

    // Truncation on the store-and-forward instance, then an intact packet
    for (int k = 0; k < 4; k++)
      expect_beat(1'b1, 32'h40 + 32'(k), (k == 3), (k == 3));
    for (int k = 0; k < 6; k++) send(1'b1, 32'h40 + 32'(k), (k == 5));
    chk("sf_err_cnt1", 64'(sf_err), 64'(1));
    expect_beat(1'b1, 32'h50, 1'b0, 1'b0);
    expect_beat(1'b1, 32'h51, 1'b1, 1'b0);
    send(1'b1, 32'h50, 1'b0);
    send(1'b1, 32'h51, 1'b1);
    drain(1'b1);
    chk("sf_err_cnt2", 64'(sf_err), 64'(1));

    // Fill: 20 attempted single-beat packets, downstream stalled
    sf_if.out_ready = 1'b0;
    acc = 0;
    d = 32'h3000;
    sf_if.ci_valid = 1'b1; sf_if.ci_end = 1'b1; sf_if.ci_data = d;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sf_acc) begin
        expect_beat(1'b1, d, 1'b1, 1'b0);
        acc++; d = d + 32'h1; sf_if.ci_data = d;
      end
    end
    chk("fill_accepted", 64'(acc),           64'(16));
    chk("fill_busy",     64'(sf_if.ci_busy), 64'(1));
    chk("fill_pkt",      64'(sf_pkt),        64'(16));
    sf_if.out_ready = 1'b1;
    tick();
    sf_if.out_ready = 1'b0;
    chk("unfill_busy", 64'(sf_if.ci_busy), 64'(0));
    tick();
    chk("beat17_acc", 64'(sf_acc), 64'(1));
    if (sf_acc) begin
      expect_beat(1'b1, d, 1'b1, 1'b0);
      d = d + 32'h1; sf_if.ci_data = d;
    end
    chk("refill_busy", 64'(sf_if.ci_busy), 64'(1));
    chk("refill_pkt",  64'(sf_pkt),        64'(16));

    // Full buffer, continuous push and pop: occupancy settles one below full
    sf_if.out_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sf_acc) begin
        expect_beat(1'b1, d, 1'b1, 1'b0);
        acc++; d = d + 32'h1; sf_if.ci_data = d;
      end
      chk("stream_pkt",   64'(sf_pkt),          64'(15));
      chk("stream_valid", 64'(sf_if.out_valid), 64'(1));
    end
    chk("stream_accepted", 64'(acc), 64'(9));
    sf_if.ci_valid = 1'b0;
    drain(1'b1);

    // Reset with half a packet buffered in the cut-through instance
    ct_if.out_ready = 1'b0;
    send(1'b0, 32'hC0, 1'b0);
    send(1'b0, 32'hC1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(ct_if.out_valid), 64'(0));
    chk("mid_rst_data",  64'(ct_if.out_data),  64'(0));
    chk("mid_rst_pkt",   64'(ct_pkt),          64'(0));
    chk("mid_rst_errc",  64'(ct_err),          64'(0));
    @(negedge s_clk); rst_n = 1'b1;
    @(posedge s_clk); #1;
    expect_beat(1'b0, 32'hD0, 1'b1, 1'b0);
    send(1'b0, 32'hD0, 1'b1);
    chk("post_rst_pkt",   64'(ct_pkt),          64'(1));
    chk("post_rst_valid", 64'(ct_if.out_valid), 64'(1));
    chk("post_rst_data",  64'(ct_if.out_data),  64'(32'hD0));
    chk("post_rst_end",   64'(ct_if.out_end),   64'(1));
    ct_if.out_ready = 1'b1;
    drain(1'b0);
    chk("post_rst_pkt0", 64'(ct_pkt), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
